// File: rtl/arcade_input_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arcade_input_pkg
// Purpose  : Shared types and the PS/2 key map for the arcade input front end.
//            Scancodes are PS/2 set 2. The key map holds 9-bit {extended, code}
//            values, so E0-prefixed keys are separate entries.
// Contents : func_e         - input function encoding (directions, buttons,
//                              start, coin, pause)
//            keymap_entry_t - one {code, player, func} mapping
//            KEYMAP_LEN     - number of key map entries
//            KEYMAP         - default map: P1 arrows(E0)/LCtrl/LAlt/Space/1/5,
//                              P2 R/F/D/G/A/S/Q/2/6, P = pause for all players
// Revision : 1.0 - initial release
// ============================================================================
package arcade_input_pkg;

  typedef enum logic [3:0] {
    F_RIGHT = 4'd0,
    F_LEFT  = 4'd1,
    F_DOWN  = 4'd2,
    F_UP    = 4'd3,
    F_BTN0  = 4'd4,
    F_BTN1  = 4'd5,
    F_BTN2  = 4'd6,
    F_BTN3  = 4'd7,
    F_BTN4  = 4'd8,
    F_BTN5  = 4'd9,
    F_START = 4'd10,
    F_COIN  = 4'd11,
    F_PAUSE = 4'd12
  } func_e;

  typedef struct packed {
    logic [8:0] code;
    logic [1:0] player;
    logic [3:0] func;
  } keymap_entry_t;

  localparam int KEYMAP_LEN = 22;

  localparam keymap_entry_t KEYMAP [KEYMAP_LEN] = '{
    // Player 1
    '{9'h175, 2'd0, F_UP},
    '{9'h172, 2'd0, F_DOWN},
    '{9'h16B, 2'd0, F_LEFT},
    '{9'h174, 2'd0, F_RIGHT},
    '{9'h014, 2'd0, F_BTN0},   // LCtrl
    '{9'h011, 2'd0, F_BTN1},   // LAlt
    '{9'h029, 2'd0, F_BTN2},   // Space
    '{9'h016, 2'd0, F_START},  // 1
    '{9'h02E, 2'd0, F_COIN},   // 5
    // Player 2
    '{9'h02D, 2'd1, F_UP},     // R
    '{9'h02B, 2'd1, F_DOWN},   // F
    '{9'h023, 2'd1, F_LEFT},   // D
    '{9'h034, 2'd1, F_RIGHT},  // G
    '{9'h01C, 2'd1, F_BTN0},   // A
    '{9'h01B, 2'd1, F_BTN1},   // S
    '{9'h015, 2'd1, F_BTN2},   // Q
    '{9'h01E, 2'd1, F_START},  // 2
    '{9'h036, 2'd1, F_COIN},   // 6
    // P pauses every player; entries for absent players are never matched
    '{9'h04D, 2'd0, F_PAUSE},
    '{9'h04D, 2'd1, F_PAUSE},
    '{9'h04D, 2'd2, F_PAUSE},
    '{9'h04D, 2'd3, F_PAUSE}
  };

endpackage
`default_nettype wire

// File: rtl/arcade_input_stretch.sv
`default_nettype none
// ============================================================================
// Module   : arcade_input_stretch
// Purpose  : Coin pulse stretcher. A rising edge of the raw coin input loads
//            the counter with COIN_PULSE-1. The registered output is
//            raw | (cnt != 0), which keeps it high for at least COIN_PULSE
//            cycles. A new edge while counting reloads the counter.
//            COIN_PULSE = 0 gives a plain registered pass-through.
// Ports    : clk     in  system clock
//            reset_n in  async active-low reset
//            raw     in  merged coin request
//            coin    out stretched, registered coin
// Revision : 1.0 - initial release
// ============================================================================
module arcade_input_stretch #(
  parameter int COIN_PULSE = 960000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic coin
);

  generate
    if (COIN_PULSE == 0) begin : g_passthrough
      logic r_coin;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_coin <= 1'b0;
        else          r_coin <= raw;
      end
      assign coin = r_coin;
    end else begin : g_stretch
      localparam int CW = (COIN_PULSE > 1) ? $clog2(COIN_PULSE) : 1;
      logic          r_prev;
      logic          r_coin;
      logic [CW-1:0] r_cnt;
      logic          w_rise;

      assign w_rise = raw & ~r_prev;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_prev <= 1'b0;
          r_coin <= 1'b0;
          r_cnt  <= '0;
        end else begin
          r_prev <= raw;
          // Uses the count before this edge, so the edge cycle plus
          // COIN_PULSE-1 countdown cycles give COIN_PULSE high cycles.
          r_coin <= raw | (r_cnt != '0);
          if (w_rise)              r_cnt <= CW'(COIN_PULSE - 1);
          else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
        end
      end
      assign coin = r_coin;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/arcade_input.sv
`default_nettype none
// ============================================================================
// Module   : arcade_input
// Purpose  : Player input front end for arcade cores. Decodes PS/2 key events
//            through KEYMAP and ORs them with HPS joystick vectors. Adds
//            optional SOCD cleaning, coin stretching, ioctl-loaded DIP bytes
//            and game index capture. All outputs are registered.
// Config   : ARCADE_INPUT_AUTOFIRE_EN - adds the autofire_mask port and the
//            AUTOFIRE_DIV parameter. Masked buttons are gated by a free-running
//            phase.
// Ports    : clk, reset_n       clock, async active-low reset
//            ps2_key[10:0]      {toggle, pressed, extended, scancode}
//            joystick           per player JW = 7+NB bits: R,L,D,U,btns,start,
//                               coin,pause
//            socd_en            cancel opposing directions
//            ioctl_wr/index/addr/data  download port (DIPs, game index)
//            autofire_mask      (autofire builds only) per-button enable
//            dirs               per player {up,down,right,left}
//            buttons/start/coin per player
//            pause              OR over players
//            dip                DIP bytes, bank 0 in [7:0]
//            game_index         low nibble of a write to ioctl_index 1
// Revision : 1.0 - initial release
// ============================================================================
module arcade_input
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int NUM_BUTTONS  = 3,
  parameter int DIP_BANKS    = 8,
  parameter int DIP_INDEX    = 254,
  parameter int COIN_PULSE   = 960000
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  ,
  parameter int AUTOFIRE_DIV = 1600000
`endif
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [10:0]                        ps2_key,
  input  logic [NUM_PLAYERS*(7+NUM_BUTTONS)-1:0] joystick,
  input  logic                               socd_en,
  input  logic                               ioctl_wr,
  input  logic [7:0]                         ioctl_index,
  input  logic [24:0]                        ioctl_addr,
  input  logic [7:0]                         ioctl_data,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  input  logic [NUM_PLAYERS*NUM_BUTTONS-1:0] autofire_mask,
`endif
  output logic [NUM_PLAYERS*4-1:0]           dirs,
  output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] buttons,
  output logic [NUM_PLAYERS-1:0]             start,
  output logic [NUM_PLAYERS-1:0]             coin,
  output logic                               pause,
  output logic [DIP_BANKS*8-1:0]             dip,
  output logic [3:0]                         game_index
);

  localparam int NB = NUM_BUTTONS;
  localparam int JW = 7 + NUM_BUTTONS;

  // Key state uses the joystick bit layout, so the merge is a plain OR.
  // A function maps to the same bit as its joystick input. Buttons beyond
  // NB have no bit.
  function automatic logic [JW-1:0] key_mask(input logic [3:0] f);
    key_mask = '0;
    if (f <= 4'(F_UP))
      key_mask = JW'(1) << int'(f);
    else if (f < 4'(F_START)) begin
      if (int'(f) - int'(F_BTN0) < NB) key_mask = JW'(1) << int'(f);
    end else if (f <= 4'(F_PAUSE))
      key_mask = JW'(1) << (4 + NB + int'(f) - int'(F_START));
  endfunction

  // ---------------------------------------------------------------- PS/2
  logic            r_primed;
  logic            r_old_tgl;
  logic            w_event;
  logic [JW-1:0]   r_key      [NUM_PLAYERS];
  logic [JW-1:0]   w_key_next [NUM_PLAYERS];

  // The first cycle after reset only captures the toggle level. The
  // toggle value at reset release therefore never looks like an event.
  assign w_event = r_primed && (r_old_tgl != ps2_key[10]);

  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      w_key_next[p] = r_key[p];
      for (int k = 0; k < KEYMAP_LEN; k++) begin
        if (w_event && KEYMAP[k].code == ps2_key[8:0] &&
            KEYMAP[k].player == 2'(p)) begin
          if (ps2_key[9]) w_key_next[p] = w_key_next[p] |  key_mask(KEYMAP[k].func);
          else            w_key_next[p] = w_key_next[p] & ~key_mask(KEYMAP[k].func);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_primed  <= 1'b0;
      r_old_tgl <= 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) r_key[p] <= '0;
    end else begin
      r_primed  <= 1'b1;
      r_old_tgl <= ps2_key[10];
      for (int p = 0; p < NUM_PLAYERS; p++) r_key[p] <= w_key_next[p];
    end
  end

  // ---------------------------------------------------------- merge/SOCD
  logic [NUM_PLAYERS*4-1:0]  w_dirs;
  logic [NUM_PLAYERS*NB-1:0] w_btns;
  logic [NUM_PLAYERS-1:0]    w_start;
  logic [NUM_PLAYERS-1:0]    w_coin;
  logic [NUM_PLAYERS-1:0]    w_pause;

  generate
    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
      logic [JW-1:0] w_raw;
      logic          w_ud_kill;
      logic          w_lr_kill;

      assign w_raw     = r_key[p] | joystick[p*JW +: JW];
      assign w_ud_kill = socd_en & w_raw[3] & w_raw[2];
      assign w_lr_kill = socd_en & w_raw[1] & w_raw[0];

      // Output order is {up, down, right, left}.
      assign w_dirs[p*4 +: 4] = {w_raw[3] & ~w_ud_kill,
                                 w_raw[2] & ~w_ud_kill,
                                 w_raw[0] & ~w_lr_kill,
                                 w_raw[1] & ~w_lr_kill};
      assign w_btns[p*NB +: NB] = w_raw[4 +: NB];
      assign w_start[p]         = w_raw[4 + NB];
      assign w_coin[p]          = w_raw[5 + NB];
      assign w_pause[p]         = w_raw[6 + NB];

      arcade_input_stretch #(
        .COIN_PULSE (COIN_PULSE)
      ) u_stretch (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (w_coin[p]),
        .coin    (coin[p])
      );
    end
  endgenerate

  // ------------------------------------------------------------ autofire
  logic [NUM_PLAYERS*NB-1:0] w_btns_fire;

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  localparam int AFW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
  logic [AFW-1:0] r_af_cnt;
  logic           r_af_phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_af_cnt   <= '0;
      r_af_phase <= 1'b0;
    end else if (r_af_cnt == AFW'(AUTOFIRE_DIV - 1)) begin
      r_af_cnt   <= '0;
      r_af_phase <= ~r_af_phase;
    end else begin
      r_af_cnt   <= r_af_cnt + 1'b1;
    end
  end

  assign w_btns_fire = w_btns & ({(NUM_PLAYERS*NB){r_af_phase}} | ~autofire_mask);
`else
  assign w_btns_fire = w_btns;
`endif

  // ------------------------------------------------------- output stage
  logic [NUM_PLAYERS*4-1:0]  r_dirs;
  logic [NUM_PLAYERS*NB-1:0] r_btns;
  logic [NUM_PLAYERS-1:0]    r_start;
  logic                      r_pause;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dirs  <= '0;
      r_btns  <= '0;
      r_start <= '0;
      r_pause <= 1'b0;
    end else begin
      r_dirs  <= w_dirs;
      r_btns  <= w_btns_fire;
      r_start <= w_start;
      r_pause <= |w_pause;
    end
  end

  assign dirs    = r_dirs;
  assign buttons = r_btns;
  assign start   = r_start;
  assign pause   = r_pause;

  // ------------------------------------------------------ ioctl download
  logic                   w_dip_wr;
  logic [DIP_BANKS*8-1:0] r_dip;
  logic [3:0]             r_game_index;

  assign w_dip_wr = ioctl_wr && (ioctl_index == 8'(DIP_INDEX));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dip        <= '0;
      r_game_index <= '0;
    end else begin
      // Only addresses that match a bank write, so out-of-range
      // addresses fall through untouched.
      for (int b = 0; b < DIP_BANKS; b++)
        if (w_dip_wr && ioctl_addr == 25'(b)) r_dip[b*8 +: 8] <= ioctl_data;
      if (ioctl_wr && ioctl_index == 8'd1) r_game_index <= ioctl_data[3:0];
    end
  end

  assign dip        = r_dip;
  assign game_index = r_game_index;

endmodule
`default_nettype wire

// File: tb/tb_arcade_input.sv
`default_nettype none
// ============================================================================
// Module   : tb_arcade_input
// Purpose  : Directed self-checking bench for arcade_input (2 players,
//            3 buttons, 8 DIP banks, COIN_PULSE = 100, AUTOFIRE_DIV = 4 when
//            ARCADE_INPUT_AUTOFIRE_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_arcade_input;

  localparam int NP = 2;
  localparam int NB = 3;
  localparam int JW = 7 + NB;
  localparam int DB = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [10:0]       ps2_key;
  logic [NP*JW-1:0]  joystick;
  logic              socd_en;
  logic              ioctl_wr;
  logic [7:0]        ioctl_index;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_data;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  logic [NP*NB-1:0]  autofire_mask;
`endif
  logic [NP*4-1:0]   dirs;
  logic [NP*NB-1:0]  buttons;
  logic [NP-1:0]     start;
  logic [NP-1:0]     coin;
  logic              pause;
  logic [DB*8-1:0]   dip;
  logic [3:0]        game_index;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arcade_input #(
    .NUM_PLAYERS  (NP),
    .NUM_BUTTONS  (NB),
    .DIP_BANKS    (DB),
    .DIP_INDEX    (254),
    .COIN_PULSE   (100)
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    ,
    .AUTOFIRE_DIV (4)
`endif
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ps2_key       (ps2_key),
    .joystick      (joystick),
    .socd_en       (socd_en),
    .ioctl_wr      (ioctl_wr),
    .ioctl_index   (ioctl_index),
    .ioctl_addr    (ioctl_addr),
    .ioctl_data    (ioctl_data),
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    .autofire_mask (autofire_mask),
`endif
    .dirs          (dirs),
    .buttons       (buttons),
    .start         (start),
    .coin          (coin),
    .pause         (pause),
    .dip           (dip),
    .game_index    (game_index)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic key(input logic pressed, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pressed, code};
  endtask

  task automatic coin_run(input bit second, output int cnt, output int last);
    cnt  = 0;
    last = 0;
    for (int k = 1; k <= 200; k++) begin
      joystick[8] = (k <= 3) || (second && k >= 50 && k <= 52);
      tick(1);
      if (coin[0]) begin
        cnt++;
        last = k;
      end
    end
    joystick[8] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c_cnt;
    int c_last;

    reset_n     = 1'b1;
    ps2_key     = {1'b1, 1'b1, 9'h175};  // toggle high with a mapped key
    joystick    = '0;
    socd_en     = 1'b0;
    ioctl_wr    = 1'b0;
    ioctl_index = '0;
    ioctl_addr  = '0;
    ioctl_data  = '0;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    autofire_mask = '0;
`endif
    #2 reset_n = 1'b0;
    tick(2);
    chk("rst_dirs", 32'(dirs), 32'h0);
    chk("rst_outs", 32'({buttons, start, coin, pause, game_index}), 32'h0);
    chk("rst_dip", 32'(|dip), 32'h0);

    // Release with toggle already high: priming must not create an event.
    reset_n = 1'b1;
    tick(4);
    chk("prime_noevt", 32'({dirs, buttons, start, coin, pause}), 32'h0);

    // Extended up arrow: visible exactly two edges later.
    key(1'b1, 9'h175);
    tick(1);
    chk("ext_up_lat1", 32'(dirs), 32'h00);
    tick(1);
    chk("ext_up", 32'(dirs), 32'h08);
    key(1'b0, 9'h175);
    tick(2);
    chk("ext_up_rel", 32'(dirs), 32'h00);
    key(1'b1, 9'h075);
    tick(2);
    chk("noext_75", 32'(dirs), 32'h00);
    key(1'b0, 9'h075);
    tick(2);

    key(1'b1, 9'h01C);
    tick(2);
    chk("p2_btn0_key", 32'(buttons), 32'b001000);
    key(1'b0, 9'h01C);
    tick(2);
    chk("p2_btn0_rel", 32'(buttons), 32'h0);
    key(1'b1, 9'h04D);
    tick(2);
    chk("pause_key", 32'(pause), 32'h1);
    key(1'b0, 9'h04D);
    tick(2);
    chk("pause_rel", 32'(pause), 32'h0);

    // SOCD.
    joystick[JW+3] = 1'b1;
    joystick[JW+2] = 1'b1;
    socd_en = 1'b1;
    tick(1);
    chk("socd_p2_ud", 32'(dirs[7:4]), 32'h0);
    socd_en = 1'b0;
    tick(1);
    chk("nosocd_p2_ud", 32'(dirs[7:4]), 32'b1100);
    joystick = '0;
    joystick[1] = 1'b1;
    joystick[0] = 1'b1;
    socd_en = 1'b1;
    tick(1);
    chk("socd_p1_lr", 32'(dirs[3:0]), 32'h0);
    socd_en = 1'b0;
    tick(1);
    chk("nosocd_p1_lr", 32'(dirs[3:0]), 32'b0011);

    // Joystick buttons, start and pause.
    joystick = '0;
    joystick[5]    = 1'b1;
    joystick[JW+7] = 1'b1;
    joystick[JW+9] = 1'b1;
    tick(1);
    chk("joy_btn1", 32'(buttons), 32'b000010);
    chk("joy_start_p2", 32'(start), 32'b10);
    chk("joy_pause_p2", 32'(pause), 32'h1);
    joystick = '0;
    tick(1);

    // Coin stretching.
    coin_run(1'b0, c_cnt, c_last);
    chk("coin_cnt", 32'(c_cnt), 32'd100);
    chk("coin_last", 32'(c_last), 32'd100);
    coin_run(1'b1, c_cnt, c_last);
    chk("coin2_cnt", 32'(c_cnt), 32'd149);
    chk("coin2_last", 32'(c_last), 32'd149);

    // DIP and game index.
    ioctl_wr = 1'b1; ioctl_index = 8'd254;
    ioctl_addr = 25'd0; ioctl_data = 8'hA5; tick(1);
    ioctl_addr = 25'd1; ioctl_data = 8'h3C; tick(1);
    ioctl_addr = 25'd9; ioctl_data = 8'hFF; tick(1);
    ioctl_index = 8'd253; ioctl_addr = 25'd2; ioctl_data = 8'h77; tick(1);
    ioctl_index = 8'd1; ioctl_addr = 25'd0; ioctl_data = 8'hB7; tick(1);
    ioctl_wr = 1'b0; ioctl_index = 8'd254; ioctl_addr = 25'd3; ioctl_data = 8'h11; tick(1);
    chk("dip01", 32'(dip[15:0]), 32'h3CA5);
    chk("dip23", 32'(dip[31:16]), 32'h0);
    chk("dip_hi", dip[63:32], 32'h0);
    chk("game_index", 32'(game_index), 32'h7);

    // Reset while a key is held discards it and the DIPs.
    key(1'b1, 9'h014);
    tick(2);
    chk("lctrl", 32'(buttons), 32'b000001);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(3);
    chk("rst_keys", 32'(buttons), 32'h0);
    chk("rst_dip_mid", 32'(dip[15:0]), 32'h0);

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    begin
      logic prev;
      int   changes, run, bad, unmasked_low;
      autofire_mask = 6'b000001;
      joystick[4] = 1'b1;
      joystick[5] = 1'b1;
      tick(2);
      prev = buttons[0];
      changes = 0; run = 0; bad = 0; unmasked_low = 0;
      for (int k = 0; k < 32; k++) begin
        tick(1);
        run++;
        if (buttons[0] != prev) begin
          if (changes > 0 && run != 4) bad++;
          changes++;
          run  = 0;
          prev = buttons[0];
        end
        if (!buttons[1]) unmasked_low++;
      end
      chk("af_period", 32'(bad), 32'h0);
      chk("af_toggles", 32'(changes >= 7), 32'h1);
      chk("af_unmasked", 32'(unmasked_low), 32'h0);
      joystick = '0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
